// File: rtl/gate_seq_pkg.sv
// Shared types and default constants for the AND-gate stimulus/check sequencer.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_ERR_W         = 8;

endpackage : gate_seq_pkg

// File: rtl/and_gate_sequencer_settle_timer.sv
// Loadable down-counter that stops at zero; zero flag tells the FSM the hold time has elapsed.
module settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : settle_timer

// File: rtl/and_gate_sequencer.sv
// Walks a gate's inputs through every combination, samples the output after a settle time
// and compares it with the expected AND-reduction, keeping error count and first failing vector.
module and_gate_sequencer
    import gate_seq_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int ERR_W         = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  fail_vec
);

    localparam int            CW       = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]  fail_vec_q, fail_vec_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;
    logic mismatch;

    settle_timer #(
        .W (CW)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (CNT_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Only meaningful in CHECK; dut_y is ignored in every other state.
    assign mismatch = (dut_y != (&vec_q));

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = SETTLE;
                    vec_d        = '0;
                    tmr_load     = 1'b1;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                end
            end

            SETTLE: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            CHECK: begin
                if (mismatch) begin
                    if (err_count_q != {ERR_W{1'b1}}) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
                end
                // All-ones is the last vector, so vec never wraps.
                if (&vec_q) begin
                    state_d = DONE;
                end else begin
                    vec_d    = vec_q + N_IN'(1);
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign stim       = (state_q == IDLE) ? '0 : vec_q;
    assign busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = (state_q == DONE) && (err_count_q == '0);
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule : and_gate_sequencer

// File: tb/tb_and_gate_sequencer.sv
// Directed bench: a 2-input instance driven by a modelled gate, and a 4-input/2-bit-counter instance.
module tb_and_gate_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    int         mode = 0;   // 0: correct AND, 1: tied 0, 2: tied 1

    logic [1:0] stim1;
    logic       dut_y1;
    logic       busy1, done1, pass1, fail_valid1;
    logic [7:0] err_count1;
    logic [1:0] fail_vec1;

    logic [3:0] stim2;
    logic       busy2, done2, pass2, fail_valid2;
    logic [1:0] err_count2;
    logic [3:0] fail_vec2;

    int checks = 0;
    int errors = 0;
    int cycles;

    always #5 clk = ~clk;

    always_comb begin
        dut_y1 = 1'b0;
        if (mode == 0)      dut_y1 = &stim1;
        else if (mode == 2) dut_y1 = 1'b1;
    end

    and_gate_sequencer #(.N_IN(2), .SETTLE_CYCLES(4), .ERR_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stim(stim1), .dut_y(dut_y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .fail_valid(fail_valid1), .fail_vec(fail_vec1)
    );

    and_gate_sequencer #(.N_IN(4), .SETTLE_CYCLES(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stim(stim2), .dut_y(1'b1),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .fail_valid(fail_valid2), .fail_vec(fail_vec2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called right after the edge that accepted start; returns cycles until done.
    task automatic wait_done1(input int budget, output int n);
        n = 0;
        while (!done1 && n < budget) begin
            tick();
            n++;
        end
        if (!done1) chk("done1_timeout", 32'(done1), 32'd1);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_stim", 32'(stim1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_pass", 32'(pass1), 0);
        chk("rst_err", 32'(err_count1), 0);
        chk("rst_fvalid", 32'(fail_valid1), 0);
        chk("rst_fvec", 32'(fail_vec1), 0);
        chk("rst_busy2", 32'(busy2), 0);

        // 1: correct gate, single-cycle start, stim order and timing
        mode = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t1_stim_k%0d", k), 32'(stim1), 32'(k / 5));
            chk($sformatf("t1_busy_k%0d", k), 32'(busy1), 1);
            chk($sformatf("t1_done_k%0d", k), 32'(done1), 0);
            tick();
        end
        chk("t1_done", 32'(done1), 1);
        chk("t1_busy_off", 32'(busy1), 0);
        chk("t1_pass", 32'(pass1), 1);
        chk("t1_err", 32'(err_count1), 0);
        chk("t1_fvalid", 32'(fail_valid1), 0);
        chk("t1_stim_last", 32'(stim1), 3);
        tick(); tick();
        chk("t1_done_held", 32'(done1), 1);

        // 2: gate tied 0 -> only vector 11 mismatches
        mode = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t2_done_drop", 32'(done1), 0);
        chk("t2_stim0", 32'(stim1), 0);
        wait_done1(100, cycles);
        chk("t2_cycles", 32'(cycles), 20);
        chk("t2_err", 32'(err_count1), 1);
        chk("t2_fvec", 32'(fail_vec1), 3);
        chk("t2_fvalid", 32'(fail_valid1), 1);
        chk("t2_pass", 32'(pass1), 0);

        // 3: gate tied 1 -> vectors 00,01,10 mismatch
        mode = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(100, cycles);
        chk("t3_cycles", 32'(cycles), 20);
        chk("t3_err", 32'(err_count1), 3);
        chk("t3_fvec", 32'(fail_vec1), 0);
        chk("t3_fvalid", 32'(fail_valid1), 1);
        chk("t3_pass", 32'(pass1), 0);

        // 4: reset mid-run while stim=10
        mode = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("t4_stim_pre", 32'(stim1), 2);
        chk("t4_err_pre", 32'(err_count1), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_stim", 32'(stim1), 0);
        chk("t4_busy", 32'(busy1), 0);
        chk("t4_done", 32'(done1), 0);
        chk("t4_err", 32'(err_count1), 0);
        chk("t4_fvalid", 32'(fail_valid1), 0);
        tick();
        chk("t4_idle_busy", 32'(busy1), 0);
        mode = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(100, cycles);
        chk("t4_cycles", 32'(cycles), 20);
        chk("t4_pass", 32'(pass1), 1);

        // 5: start held high throughout
        mode = 2;
        start1 = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t5_stim_k%0d", k), 32'(stim1), 32'(k / 5));
            tick();
        end
        chk("t5_done", 32'(done1), 1);
        chk("t5_err", 32'(err_count1), 3);
        tick();
        chk("t5_done_drop", 32'(done1), 0);
        chk("t5_busy", 32'(busy1), 1);
        chk("t5_err_clr", 32'(err_count1), 0);
        chk("t5_stim0", 32'(stim1), 0);
        start1 = 1'b0;
        wait_done1(100, cycles);
        chk("t5_cycles", 32'(cycles), 20);

        // 6: 4-input instance, gate tied 1, 2-bit saturating counter
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t6_busy", 32'(busy2), 1);
        cycles = 0;
        while (!done2 && cycles < 200) begin
            tick();
            cycles++;
        end
        chk("t6_cycles", 32'(cycles), 80);
        chk("t6_done", 32'(done2), 1);
        chk("t6_err_sat", 32'(err_count2), 3);
        chk("t6_fvec", 32'(fail_vec2), 0);
        chk("t6_fvalid", 32'(fail_valid2), 1);
        chk("t6_pass", 32'(pass2), 0);
        chk("t6_stim_last", 32'(stim2), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_and_gate_sequencer
